// File: rtl/osd_fetch_ctrl.sv
// OSD line/burst fetch sequencer: clears the OSD FIFO per frame and issues read bursts that fit.
// Optional OSD_PINGPONG_EN alternates frames between cfg_base0 and cfg_base1.
module osd_fetch_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int LEVEL_W    = 10,
    parameter int FIFO_DEPTH = 512,
    parameter int BURST_LEN  = 64,
    parameter int WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] cfg_base0,
    input  logic [ADDR_W-1:0] cfg_base1,
    input  logic [ADDR_W-1:0] cfg_stride,
    input  logic [LEN_W-1:0]  cfg_line_words,
    input  logic [LEN_W-1:0]  cfg_lines,
    input  logic [LEVEL_W-1:0] fifo_level,
    output logic              fifo_aclr,
    output logic              rd_cmd_valid,
    input  logic              rd_cmd_ready,
    output logic [ADDR_W-1:0] rd_cmd_addr,
    output logic [LEN_W-1:0]  rd_cmd_len,
    input  logic              rd_done,
    output logic              busy,
    output logic              frame_done,
    output logic              err_overrun,
    output logic              buf_sel,
    output logic [2:0]        dbg_state
);

    // Command handshake: rd_cmd_valid rises with addr/len already stable; all three
    // hold unchanged until the cycle rd_cmd_ready is seen high, then valid drops.
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CLEAR      = 3'd1,
        S_WAIT_SPACE = 3'd2,
        S_CMD        = 3'd3,
        S_WAIT_DONE  = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] BURST_LEN_L = LEN_W'(BURST_LEN);

    state_t            state;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  line_words_q;
    logic [LEN_W-1:0]  lines_q;
    logic [LEN_W-1:0]  words_left;
    logic [LEN_W-1:0]  line;
    logic              clr_cnt;
    logic              restart_pend;

    logic              accept_start;
    logic              start_sel;
    logic [ADDR_W-1:0] start_base;
    logic [LEN_W-1:0]  burst_len;
    logic [31:0]       space_need;
    logic              has_space;
    logic              line_end;
    logic              last_line;
    logic [ADDR_W-1:0] burst_bytes;

    // A frame start is taken from IDLE only when enabled; while busy it always restarts.
    assign accept_start = frame_start && ((state != S_IDLE) || enable);

`ifdef OSD_PINGPONG_EN
    logic next_sel;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            next_sel <= 1'b0;
        else if (accept_start)
            next_sel <= ~next_sel;
    end
    assign start_sel = next_sel;
`else
    assign start_sel = 1'b0;
`endif

    assign start_base  = start_sel ? cfg_base1 : cfg_base0;
    assign burst_len   = (words_left < BURST_LEN_L) ? words_left : BURST_LEN_L;
    assign space_need  = 32'(fifo_level) + 32'(burst_len);
    assign has_space   = space_need <= 32'(FIFO_DEPTH);
    assign line_end    = (words_left == rd_cmd_len);
    assign last_line   = (({1'b0, line} + (LEN_W+1)'(1)) == {1'b0, lines_q});
    assign burst_bytes = ADDR_W'(rd_cmd_len) * ADDR_W'(WORD_BYTES);
    assign dbg_state   = state;

    // Frame walk context; an aborted frame's final rd_done must not disturb the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stride_q     <= '0;
            line_words_q <= '0;
            lines_q      <= '0;
            line_base    <= '0;
            addr         <= '0;
            words_left   <= '0;
            line         <= '0;
            buf_sel      <= 1'b0;
        end else if (accept_start) begin
            stride_q     <= cfg_stride;
            line_words_q <= cfg_line_words;
            lines_q      <= cfg_lines;
            line_base    <= start_base;
            addr         <= start_base;
            words_left   <= cfg_line_words;
            line         <= '0;
            buf_sel      <= start_sel;
        end else if (state == S_WAIT_DONE && rd_done && !restart_pend) begin
            if (line_end) begin
                line       <= line + LEN_W'(1);
                line_base  <= line_base + stride_q;
                addr       <= line_base + stride_q;
                words_left <= line_words_q;
            end else begin
                words_left <= words_left - rd_cmd_len;
                addr       <= addr + burst_bytes;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            fifo_aclr    <= 1'b0;
            rd_cmd_valid <= 1'b0;
            rd_cmd_addr  <= '0;
            rd_cmd_len   <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            err_overrun  <= 1'b0;
            clr_cnt      <= 1'b0;
            restart_pend <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            err_overrun <= frame_start && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (accept_start) begin
                        state     <= S_CLEAR;
                        busy      <= 1'b1;
                        fifo_aclr <= 1'b1;
                        clr_cnt   <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (frame_start) begin
                        clr_cnt <= 1'b0;
                    end else if (!clr_cnt) begin
                        clr_cnt <= 1'b1;
                    end else begin
                        fifo_aclr <= 1'b0;
                        if (lines_q == '0 || line_words_q == '0) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            state <= S_WAIT_SPACE;
                        end
                    end
                end
                S_WAIT_SPACE: begin
                    if (frame_start) begin
                        state     <= S_CLEAR;
                        fifo_aclr <= 1'b1;
                        clr_cnt   <= 1'b0;
                    end else if (!enable) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (has_space) begin
                        state        <= S_CMD;
                        rd_cmd_valid <= 1'b1;
                        rd_cmd_addr  <= addr;
                        rd_cmd_len   <= burst_len;
                    end
                end
                S_CMD: begin
                    if (frame_start)
                        restart_pend <= 1'b1;
                    if (rd_cmd_ready) begin
                        rd_cmd_valid <= 1'b0;
                        state        <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (rd_done) begin
                        restart_pend <= 1'b0;
                        if (restart_pend || frame_start) begin
                            state     <= S_CLEAR;
                            fifo_aclr <= 1'b1;
                            clr_cnt   <= 1'b0;
                        end else if (line_end && last_line) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end else if (!enable) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            state <= S_WAIT_SPACE;
                        end
                    end else if (frame_start) begin
                        restart_pend <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/osd_fetch_ctrl.md
# osd_fetch_ctrl

Sequences line-by-line burst fetches of OSD pixel data from frame memory into the OSD pixel FIFO that feeds the OSD stream output. On each frame start it clears the FIFO, walks the configured lines and words, and issues read-master bursts only when the FIFO has room for the whole burst. One burst is outstanding at a time.

## Interface
- ADDR_W, 32, byte-address width
- LEN_W, 16, width of line/word counts and burst length
- LEVEL_W, 10, width of FIFO fill level
- FIFO_DEPTH, 512, FIFO capacity in words
- BURST_LEN, 64, maximum words per burst (≥1, ≤FIFO_DEPTH)
- WORD_BYTES, 4, bytes per FIFO word
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  fetch enable
- frame_start  in  1  one-cycle frame start pulse
- cfg_base0 / cfg_base1  in  ADDR_W  frame buffer base addresses
- cfg_stride  in  ADDR_W  line-to-line byte stride
- cfg_line_words  in  LEN_W  words per line
- cfg_lines  in  LEN_W  lines per frame
- fifo_level  in  LEVEL_W  words currently in FIFO
- fifo_aclr  out  1  FIFO clear request
- rd_cmd_valid  out  1  burst command valid
- rd_cmd_ready  in  1  read master accepts command
- rd_cmd_addr  out  ADDR_W  burst byte address
- rd_cmd_len  out  LEN_W  burst length in words
- rd_done  in  1  one-cycle pulse: last word of burst written to FIFO
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse, frame fully fetched
- err_overrun  out  1  one-cycle pulse, frame_start while busy
- buf_sel  out  1  buffer used by current frame

## Operation
- All outputs registered; reset value 0 for every output.
- States: IDLE, CLEAR, WAIT_SPACE, CMD, WAIT_DONE.
- IDLE: frame_start & enable -> CLEAR; config latched; addr = line_base = selected base; words_left = cfg_line_words; line = 0.
- CLEAR: fifo_aclr high exactly 2 cycles, then WAIT_SPACE. If cfg_lines==0 or cfg_line_words==0: frame_done pulse, -> IDLE, no commands.
- WAIT_SPACE: len = min(BURST_LEN, words_left). If FIFO_DEPTH − fifo_level ≥ len -> CMD. If enable low -> IDLE.
- CMD: rd_cmd_valid high; addr/len held stable until rd_cmd_ready; valid never dropped before acceptance. On ready -> WAIT_DONE.
- WAIT_DONE: on rd_done: words_left −= len; addr += len×WORD_BYTES. If words_left==0: line += 1; if line==cfg_lines -> frame_done pulse, IDLE; else line_base += cfg_stride, addr = line_base, words_left = cfg_line_words. Then WAIT_SPACE (or IDLE if enable low).
- Address arithmetic modulo 2^ADDR_W (wraps silently).
- frame_start while busy: err_overrun pulse; restart pending set. WAIT_SPACE/CLEAR -> CLEAR immediately with new config; CMD completes handshake, WAIT_DONE waits rd_done, then CLEAR. No frame_done for the aborted frame.
- rd_done outside WAIT_DONE ignored. Reset mid-operation: all state and outputs to 0 asynchronously.

## Timing
- frame_start at cycle N (IDLE) -> busy, fifo_aclr at N+1, N+2; WAIT_SPACE N+3; earliest rd_cmd_valid N+4.
- rd_cmd_ready at cycle M -> rd_cmd_valid low at M+1.
- rd_done at cycle K -> earliest next rd_cmd_valid K+2; final burst: frame_done at K+1, busy low K+1.
- Space check uses fifo_level sampled in WAIT_SPACE.

## Configuration
- OSD_PINGPONG_EN defined: buf_sel toggles on each accepted frame_start (first frame uses cfg_base0, then cfg_base1, alternating); base = buf_sel ? cfg_base1 : cfg_base0.
- Undefined: cfg_base0 always used, cfg_base1 ignored, buf_sel held 0.

## Test plan
- cfg_lines=2, cfg_line_words=100, base0=0x1000, stride=0x200, fifo_level=0 -> commands (0x1000,64),(0x1100,36),(0x1200,64),(0x1300,36); frame_done once after 4th rd_done.
- fifo_level=460 in WAIT_SPACE, len 64 -> no rd_cmd_valid; level drops to 448 -> valid next cycle.
- rd_cmd_ready held low 10 cycles -> valid, addr, len stable all 10 cycles.
- frame_start during WAIT_DONE -> err_overrun pulse; after rd_done, fifo_aclr 2 cycles, fetch restarts at new base; no frame_done for first frame.
- cfg_lines=0 -> fifo_aclr 2 cycles, frame_done, zero commands.
- OSD_PINGPONG_EN, three frames base0=0x1000, base1=0x8000 -> first addresses 0x1000, 0x8000, 0x1000; buf_sel 0,1,0.
